// File: rtl/rv32_pkg.sv
// rv32_pkg
// Shared definitions for the multicycle RV32I control path: opcode
// constants, immediate-format codes, ALU operation classes and codes,
// datapath mux select codes and the controller state encoding.
package rv32_pkg;

  // Major opcodes (instr[6:0]) recognised by the controller
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  // Immediate generator format; values are the imm_src port codes
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // ALU operation codes driven on alu_control
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctl_e;

  // ALU operand A sources; 11 is a constant zero, used by LUI
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  // ALU operand B sources
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  // Result bus sources
  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR2,
    S_UPPER,
    S_TRAP
  } ctrl_state_e;

  // Immediate format needed in DECODE, where the branch/jump target
  // is precomputed from the old PC
  function automatic imm_src_e decode_imm_src(input logic [6:0] opcode);
    case (opcode)
      OP_BRANCH: decode_imm_src = IMM_B;
      OP_JAL:    decode_imm_src = IMM_J;
      default:   decode_imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder
// Combinational translation of the FSM's operation class plus the
// instruction function fields into a concrete ALU operation.
// Ports:
//   alu_op      in  operation class from the controller FSM
//   funct3      in  instr[14:12]
//   funct7_5    in  instr[30] (SUB / SRA selector)
//   op_5        in  instr[5], distinguishes R-type from I-type ALU ops
//   alu_control out ALU operation code (alu_ctl_e)
module alu_decoder
  import rv32_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        op_5,
  output logic [3:0]  alu_control
);

  // instr[30] means SUB only for R-type; for I-type it is part of the
  // immediate, except for the shift-right pair where it picks SRAI.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM of the multicycle RV32I core: sequences fetch,
// decode, execute, memory and writeback for one instruction at a time,
// drives the datapath selects/enables and runs the memory req/ready
// handshake with an optional wait timeout.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   instr        instruction register contents
//   zero         ALU result == 0 (branch condition)
//   mem_ready    memory completes the current request this cycle
//   imm_src      immediate format select
//   alu_src_a/b  ALU operand selects
//   alu_control  ALU operation
//   result_src   result bus select
//   adr_src      memory address select (0 PC, 1 result)
//   mem_req/we   memory request and write qualifier
//   ir_write     load IR and old PC
//   pc_write     PC update enable, including taken branches
//   reg_write    register-file write enable
//   retired      one-cycle pulse at instruction completion
//   fault        sticky illegal-opcode / memory-timeout flag
module multicycle_controller
  import rv32_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  imm_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic [1:0]  result_src,
  output logic        adr_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        retired,
  output logic        fault
);

  localparam int CNT_W = (WAIT_LIMIT < 255) ? 8 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_e      state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             pc_upd;
  logic             branch;
  alu_op_e          alu_op;
  imm_src_e         imm_sel;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // A pending request has waited the full budget; the request is
  // withdrawn this cycle and the FSM traps.
  assign timeout = (WAIT_LIMIT != 0) && (wait_cnt == CNT_W'(WAIT_LIMIT));

  // State, wait counter and sticky fault. The counter saturates so a
  // disabled timeout never wraps back into a small count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP)
        fault <= 1'b1;
      if (mem_ready)
        wait_cnt <= '0;
      else if (mem_req && (wait_cnt != CNT_MAX))
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and output decode. Outputs are Moore apart from the
  // handshake completions (ir_write/pc_upd in FETCH, retired in
  // MEMWRITE) which qualify on mem_ready. Everything is held at zero
  // while reset is asserted.
  always_comb begin
    next_state = state;
    imm_sel    = IMM_I;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALU_OUT;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_upd     = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    retired    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          if (timeout) begin
            next_state = S_TRAP;
          end else begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_write   = 1'b1;
              pc_upd     = 1'b1;
              next_state = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          imm_sel   = decode_imm_src(opcode);
          case (opcode)
            OP_LOAD, OP_STORE: next_state = S_MEMADR;
            OP_R:              next_state = S_EXEC_R;
            OP_I:              next_state = S_EXEC_I;
            OP_BRANCH:         next_state = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
            OP_JAL:            next_state = S_JAL;
            OP_JALR:           next_state = S_JALR;
            OP_LUI, OP_AUIPC:  next_state = S_UPPER;
            default:           next_state = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          imm_sel    = opcode[5] ? IMM_S : IMM_I;
          next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          adr_src = 1'b1;
          if (timeout) begin
            next_state = S_TRAP;
          end else begin
            mem_req = 1'b1;
            if (mem_ready)
              next_state = S_MEMWB;
          end
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
          retired    = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWRITE: begin
          adr_src = 1'b1;
          if (timeout) begin
            next_state = S_TRAP;
          end else begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ready) begin
              retired    = 1'b1;
              next_state = S_FETCH;
            end
          end
        end
        S_EXEC_R: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op     = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_EXEC_I: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          alu_op     = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          retired    = 1'b1;
          next_state = S_FETCH;
        end
        // The ALU output register still holds the target from DECODE
        // while the ALU compares rs1/rs2.
        S_BRANCH: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op     = ALUOP_SUB;
          branch     = 1'b1;
          retired    = 1'b1;
          next_state = S_FETCH;
        end
        // PC takes the DECODE target; the ALU forms old PC + 4 for rd.
        S_JAL, S_JALR2: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          pc_upd     = 1'b1;
          next_state = S_ALUWB;
        end
        S_JALR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          next_state = S_JALR2;
        end
        S_UPPER: begin
          imm_sel    = IMM_U;
          alu_src_a  = opcode[5] ? SRC_A_ZERO : SRC_A_OLD_PC;
          alu_src_b  = SRC_B_IMM;
          next_state = S_ALUWB;
        end
        S_TRAP: next_state = S_TRAP;
        default: next_state = S_TRAP;
      endcase
    end
  end

  assign imm_src  = imm_sel;
  assign pc_write = pc_upd | (branch & (zero ^ funct3[0]));

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (instr[30]),
    .op_5        (opcode[5]),
    .alu_control (alu_control)
  );

endmodule
